// File: rtl/strm_pkt_gen.sv
// Valid/ready packet source: runs of pkt_num packets of pkt_len incrementing beats.
// Define STRM_PKT_GEN_GAP_EN to enable the GAP state and inter-packet idle cycles.
//
// state | meaning
// IDLE  | outputs quiet, waiting for start
// SEND  | offering packet beats, vld_m high
// GAP   | inter-packet idle (STRM_PKT_GEN_GAP_EN only)
// FIN   | one cycle, drives done
module strm_pkt_gen #(
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LENW-1:0] pkt_len,
    input  logic [7:0]      pkt_num,
    input  logic [DW-1:0]   seed,
    input  logic [3:0]      gap,
    output logic [DW-1:0]   data_m,
    output logic            vld_m,
    output logic            last_m,
    input  logic            ready_m,
    output logic            busy,
    output logic            done,
    output logic [15:0]     beat_total,
    output logic [15:0]     stall_cnt
);

`ifdef STRM_PKT_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd3} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] beat_idx;
    logic [7:0]      num_q;
    logic [7:0]      pkt_cnt;
    logic            last_r;
    logic            acc;
    logic            launch;
    logic            final_pkt;

`ifdef STRM_PKT_GEN_GAP_EN
    logic [3:0]      gap_q;
    logic [3:0]      gap_cnt;
`else
    logic            unused_gap;
    assign unused_gap = ^gap;
`endif

    assign acc       = vld_m & ready_m;
    assign launch    = (state == IDLE) & start & (pkt_num != 8'd0);
    assign final_pkt = (pkt_cnt == (num_q - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (pkt_num == 8'd0) ? FIN : SEND;
            end
            SEND: begin
                if (acc && last_r) begin
                    if (final_pkt) state_nxt = FIN;
`ifdef STRM_PKT_GEN_GAP_EN
                    else if (gap_q != 4'd0) state_nxt = GAP;
`endif
                    else state_nxt = SEND;
                end
            end
`ifdef STRM_PKT_GEN_GAP_EN
            GAP: begin
                if (gap_cnt == 4'd1) state_nxt = SEND;
            end
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from flops, so ready_m never reaches vld_m.
    always_comb begin
        vld_m  = (state == SEND);
        last_m = (state == SEND) & last_r;
        busy   = (state != IDLE);
        done   = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            num_q    <= '0;
            beat_idx <= '0;
            pkt_cnt  <= '0;
            last_r   <= 1'b0;
            data_m   <= '0;
        end else if (launch) begin
            len_q    <= (pkt_len == '0) ? LENW'(1) : pkt_len;
            num_q    <= pkt_num;
            beat_idx <= '0;
            pkt_cnt  <= '0;
            last_r   <= (pkt_len <= LENW'(1));
            data_m   <= seed;
        end else if (acc) begin
            data_m <= data_m + DW'(1);
            if (last_r) begin
                beat_idx <= '0;
                pkt_cnt  <= pkt_cnt + 8'd1;
                last_r   <= (len_q == LENW'(1));
            end else begin
                beat_idx <= beat_idx + LENW'(1);
                last_r   <= ((beat_idx + LENW'(1)) == (len_q - LENW'(1)));
            end
        end
    end

`ifdef STRM_PKT_GEN_GAP_EN
    // gap_cnt is a down-counter; GAP exits when it reaches terminal count 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            if (launch) gap_q <= gap;
            if (state == SEND && state_nxt == GAP) gap_cnt <= gap_q;
            else if (state == GAP)                 gap_cnt <= gap_cnt - 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total <= '0;
            stall_cnt  <= '0;
        end else begin
            if (acc) beat_total <= beat_total + 16'd1;
            if (vld_m && !ready_m && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_strm_pkt_gen.sv
// Scoreboard bench for strm_pkt_gen: stimulus pushes expected beats, a monitor pops on acceptance.
module tb_strm_pkt_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [7:0]  pkt_num = '0;
    logic [31:0] seed = '0;
    logic [3:0]  gap = '0;
    logic [31:0] data_m;
    logic        vld_m, last_m, busy, done;
    logic        ready_m = 1'b1;
    logic [15:0] beat_total, stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0;
    logic [32:0] exp_q[$];   // {last, data}

    strm_pkt_gen #(.DW(32), .LENW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pkt_len(pkt_len), .pkt_num(pkt_num),
        .seed(seed), .gap(gap), .data_m(data_m), .vld_m(vld_m), .last_m(last_m),
        .ready_m(ready_m), .busy(busy), .done(done), .beat_total(beat_total), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop on acceptance, and check stability while stalled.
    logic        p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
    logic [31:0] p_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_vld = 1'b0;
        end else begin
            if (p_vld && !p_rdy) begin
                chk("hold_vld", {31'd0, vld_m}, 32'd1);
                chk("hold_data", data_m, p_data);
                chk("hold_last", {31'd0, last_m}, {31'd0, p_last});
            end
            if (vld_m && ready_m) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", data_m, 32'hDEAD_BEEF);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", data_m, e[31:0]);
                    chk("beat_last", {31'd0, last_m}, {31'd0, e[32]});
                end
            end
            p_vld = vld_m; p_rdy = ready_m; p_data = data_m; p_last = last_m;
        end
    end

    task automatic push_run(input logic [31:0] s, input int len, input int num);
        int l;
        logic [31:0] d;
        l = (len == 0) ? 1 : len;
        d = s;
        for (int p = 0; p < num; p++)
            for (int b = 0; b < l; b++) begin
                exp_q.push_back({(b == l - 1), d});
                d = d + 32'd1;
            end
    endtask

    // Called #1 after an edge; returns #1 after the start edge T.
    task automatic do_start(input logic [31:0] s, input int len, input int num, input int g);
        seed = s; pkt_len = 16'(len); pkt_num = 8'(num); gap = 4'(g);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int guard;
        guard = 0;
        while (!done && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({name, "_busy_off"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, guard;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {31'd0, vld_m}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_data", data_m, 32'd0);
        chk("idle_beats", {16'd0, beat_total}, 32'd0);
        chk("idle_stall", {16'd0, stall_cnt}, 32'd0);

        // basic run
        push_run(32'h100, 4, 2);
        do_start(32'h100, 4, 2, 0);
        chk("basic_vld_t1", {31'd0, vld_m}, 32'd1);
        chk("basic_busy_t1", {31'd0, busy}, 32'd1);
        wait_done("basic", 8);
        chk("basic_beats", {16'd0, beat_total}, 32'd8);

        // backpressure on 0x102
        push_run(32'h100, 4, 2);
        do_start(32'h100, 4, 2, 0);
        guard = 0;
        while (data_m != 32'h102 && guard < 20) begin @(posedge clk); #1; guard++; end
        ready_m = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_data", data_m, 32'h102);
        end
        ready_m = 1'b1;
        wait_done("bp", 11);
        chk("bp_stall", {16'd0, stall_cnt}, 32'd3);
        chk("bp_beats", {16'd0, beat_total}, 32'd16);

        // gap (ignored when the feature is compiled out)
        push_run(32'h200, 2, 3);
        do_start(32'h200, 2, 3, 5);
        lows = 0; guard = 0;
        while (!done && guard < 100) begin
            if (!vld_m) lows++;
            @(posedge clk); #1;
            guard++;
        end
`ifdef STRM_PKT_GEN_GAP_EN
        chk("gap_low_cycles", 32'(lows), 32'd10);
        chk("gap_latency", 32'(cyc - t0), 32'd16);
`else
        chk("gap_low_cycles", 32'(lows), 32'd0);
        chk("gap_latency", 32'(cyc - t0), 32'd6);
`endif
        chk("gap_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        chk("gap_beats", {16'd0, beat_total}, 32'd22);
        chk("gap_stall", {16'd0, stall_cnt}, 32'd3);

        // pkt_len = 0 -> single beat with last
        push_run(32'h55, 0, 1);
        do_start(32'h55, 0, 1, 0);
        chk("len0_last", {31'd0, last_m}, 32'd1);
        wait_done("len0", 1);
        chk("len0_beats", {16'd0, beat_total}, 32'd23);

        // empty run
        do_start(32'h77, 4, 0, 0);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_vld", {31'd0, vld_m}, 32'd0);
        wait_done("empty", 0);
        chk("empty_beats", {16'd0, beat_total}, 32'd23);

        // ignored start, then reset mid-packet
        push_run(32'h300, 4, 2);
        do_start(32'h300, 4, 2, 0);
        repeat (2) begin @(posedge clk); #1; end
        seed = 32'h999; pkt_num = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd0);
        chk("ign_vld", {31'd0, vld_m}, 32'd1);
        chk("ign_data", data_m, 32'h303);
        @(posedge clk); #1;
        chk("ign_data2", data_m, 32'h304);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, vld_m}, 32'd0);
        chk("mid_rst_last", {31'd0, last_m}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", data_m, 32'd0);
        chk("mid_rst_beats", {16'd0, beat_total}, 32'd0);
        chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_run(32'h10, 3, 1);
        do_start(32'h10, 3, 1, 0);
        chk("fresh_data", data_m, 32'h10);
        wait_done("fresh", 3);
        chk("fresh_beats", {16'd0, beat_total}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/strm_pkt_gen.md
# strm_pkt_gen

Valid/ready stream transmitter that produces packets of incrementing data on a master stream port. It sits upstream of the stream register slices and acts as the source end of the same `vld`/`ready`/`data` handshake. It provides a deterministic traffic source for bring-up and loopback checking, with beat and stall counters for throughput measurement.

## Interface
Parameters:
- `DW`, 32, data width of `data_m` and `seed`.
- `LENW`, 16, width of `pkt_len`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `pkt_len` in LENW: beats per packet; 0 is treated as 1.
- `pkt_num` in 8: packets per run; 0 gives an empty run.
- `seed` in DW: data value of the first beat of the run.
- `gap` in 4: idle cycles between packets (see Configuration).
- `data_m` out DW: stream data.
- `vld_m` out 1: stream valid.
- `last_m` out 1: final beat of the current packet.
- `ready_m` in 1: downstream ready.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `beat_total` out 16: accepted beats since reset; wraps.
- `stall_cnt` out 16: cycles with `vld_m & !ready_m`; saturates at 0xFFFF.

## Operation
- Beat accepted (`acc`) = `vld_m & ready_m`.
- States:
  - IDLE: outputs quiet.
  - SEND: packet data is being offered.
  - GAP: inter-packet idle cycles.
  - FIN: one cycle; drives `done`.
- IDLE → SEND on `start` with `pkt_num != 0`. On that edge, latch `pkt_len` (0 → 1), `pkt_num`, `gap` and `seed`. `data_m <= seed`, beat index ← 0, packet count ← 0.
- IDLE → FIN on `start` with `pkt_num == 0`. No beats are sent.
- `start` outside IDLE is ignored. Inputs are not re-sampled during a run.
- In SEND:
  - `vld_m` = 1.
  - `last_m` = 1 when beat index == latched length − 1.
  - Each `acc` increments `data_m` by 1, modulo 2^DW. The data sequence is continuous across packets within a run.
- On `acc` with `last_m`:
  - Increment the packet count and reset the beat index.
  - If this was the final packet → FIN.
  - Else, if latched gap > 0 (macro enabled) → GAP.
  - Else → stay in SEND with `vld_m` held high (back-to-back).
- GAP: `vld_m` = 0 for exactly `gap` cycles, then → SEND.
- FIN: `done` = 1 for one cycle, then → IDLE; `vld_m` = 0.
- Handshake rule: once `vld_m` is high, `vld_m`, `data_m` and `last_m` stay stable until `acc`. `ready_m` may toggle freely. No combinational path from `ready_m` to `vld_m`.
- `beat_total` increments on every `acc`; 0xFFFF wraps to 0.
- `stall_cnt` increments on `vld_m & !ready_m` and holds at 0xFFFF.
- Both counters clear only on reset.

## Timing
- Reset values:
  - `vld_m`, `last_m`, `busy`, `done` = 0.
  - `data_m`, `beat_total`, `stall_cnt` = 0.
  - State = IDLE.
- Reset asserted mid-packet: all outputs return to reset values immediately, regardless of handshake state.
- All outputs are registered.
- `start` at edge T → `vld_m` = 1 and `busy` = 1 from cycle T+1.
- With `ready_m` held high, throughput is 1 beat/cycle. A run without gaps takes `pkt_len*pkt_num` cycles in SEND, then 1 cycle in FIN.
- Final `acc` at edge T → `done` = 1 and `vld_m` = 0 during cycle T+1. `busy` = 0 from T+2. A new `start` is accepted from T+2.
- Empty run: `start` at T → `done` during T+1, with no `vld_m`.

## Configuration
- `STRM_PKT_GEN_GAP_EN` defined:
  - GAP state present.
  - `gap` is honoured, giving 0–15 idle cycles between packets of a run.
  - No gap is inserted after the final packet.
- Not defined:
  - GAP state and gap latch are removed.
  - `gap` input is ignored.
  - Packets are always back-to-back with `vld_m` continuously high across packet boundaries.

## Test plan
- Basic run:
  - Stimulus: `seed`=0x100, `pkt_len`=4, `pkt_num`=2, `gap`=0, `ready_m`=1.
  - Response: 8 consecutive beats 0x100..0x107; `last_m` on 0x103 and 0x107; `done` one cycle later; `beat_total`=8.
- Backpressure:
  - Stimulus: as above, with `ready_m` low for 3 cycles while the beat with data 0x102 is offered.
  - Response: `data_m` held at 0x102 with `vld_m` high for those cycles; `stall_cnt`=3; sequence unchanged.
- Gap (macro defined):
  - Stimulus: `pkt_len`=2, `pkt_num`=3, `gap`=5.
  - Response: `vld_m` low for exactly 5 cycles after each of the first two `last_m` acceptances; no gap before `done`.
- Degenerate inputs:
  - `pkt_len`=0, `pkt_num`=1 → single beat with `last_m`=1.
  - `pkt_num`=0 → `done` at T+1, no `vld_m`, `beat_total` unchanged.
- Ignored start and reset:
  - Stimulus: second `start` pulsed mid-run, then `rst_n` asserted mid-packet.
  - Response: second `start` ignored; on reset, outputs and counters drop to 0 immediately; a fresh `start` after release runs normally.
